// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the fetch sequencer and its counters.
package fetch_pkg;

   localparam int         PC_W_DEF       = 8;
   localparam int         CNT_W_DEF      = 16;
   localparam logic [7:0] START_ADDR_DEF = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Start is only honoured when the core is not already executing.
   function automatic logic can_start(input fetch_state_t s);
      return (s != RUN);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Architectural PC, next-PC selection and run/halt control for the 8-bit core,
// plus saturating cycle and retired-instruction counters.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              PC_W       = PC_W_DEF,
   parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
   parameter int              CNT_W      = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             Branch_Taken,
   input  logic [PC_W-1:0]  PC_New,
   output logic [PC_W-1:0]  PC_Curr,
   output logic             Fetch_Valid,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] Instr_Count,
   output logic [CNT_W-1:0] Cycle_Count
);

   fetch_state_t    state_q;
   logic [PC_W-1:0] pc_q;
   logic            done_q;
   logic            start_go;
   logic            in_run;

   assign in_run      = (state_q == RUN);
   assign start_go    = can_start(state_q) && Start;
   assign Fetch_Valid = in_run && !Stall;

   // Reset release is expected to be synchronised to CLK upstream.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, HALTED: begin
               if (Start) begin
                  state_q <= RUN;
                  pc_q    <= START_ADDR;
               end
            end
            RUN: begin
               if (!Stall) begin
                  // Halt outranks a simultaneous taken branch; PC stays on the halt.
                  if (Halt) begin
                     state_q <= HALTED;
                     done_q  <= 1'b1;
                  end else if (Branch_Taken) begin
                     pc_q <= PC_New;
                  end else begin
                     pc_q <= pc_q + PC_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign PC_Curr = pc_q;
   assign Running = in_run;
   assign Done    = done_q;

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .CLK   (CLK),
      .Reset (Reset),
      .clr   (start_go),
      .inc   (Fetch_Valid),
      .count (Instr_Count)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .CLK   (CLK),
      .Reset (Reset),
      .clr   (start_go),
      .inc   (in_run),
      .count (Cycle_Count)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, random run against a
// behavioural model, reset corner cases and a narrow-counter saturation build.
module tb_fetch_sequencer;

   logic        CLK;
   logic        Reset;
   logic        Start;
   logic        Stall;
   logic        Halt;
   logic        Branch_Taken;
   logic [7:0]  PC_New;
   logic [7:0]  PC_Curr;
   logic        Fetch_Valid;
   logic        Running;
   logic        Done;
   logic [15:0] Instr_Count;
   logic [15:0] Cycle_Count;

   logic        rst4;
   logic        start4;
   logic        stall4;
   logic        halt4;
   logic        br4;
   logic [7:0]  pcnew4;
   logic [7:0]  pc4;
   logic        fv4;
   logic        run4;
   logic        done4;
   logic [3:0]  ic4;
   logic [3:0]  cc4;

   int nvec  = 0;
   int nfail = 0;

   fetch_sequencer dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Start        (Start),
      .Stall        (Stall),
      .Halt         (Halt),
      .Branch_Taken (Branch_Taken),
      .PC_New       (PC_New),
      .PC_Curr      (PC_Curr),
      .Fetch_Valid  (Fetch_Valid),
      .Running      (Running),
      .Done         (Done),
      .Instr_Count  (Instr_Count),
      .Cycle_Count  (Cycle_Count)
   );

   fetch_sequencer #(.CNT_W(4)) dut4 (
      .CLK          (CLK),
      .Reset        (rst4),
      .Start        (start4),
      .Stall        (stall4),
      .Halt         (halt4),
      .Branch_Taken (br4),
      .PC_New       (pcnew4),
      .PC_Curr      (pc4),
      .Fetch_Valid  (fv4),
      .Running      (run4),
      .Done         (done4),
      .Instr_Count  (ic4),
      .Cycle_Count  (cc4)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        start;
      logic        stall;
      logic        halt;
      logic        br;
      logic [7:0]  pcnew;
      logic [7:0]  pc;
      logic        run;
      logic        fv;
      logic        done;
      logic [15:0] ic;
      logic [15:0] cc;
   } vec_t;

   vec_t tbl[20];

   // Behavioural model: 0 = idle, 1 = running, 2 = halted.
   localparam int CMAX = 65535;
   int m_state;
   int m_pc;
   int m_ic;
   int m_cc;
   bit m_done;

   function automatic vec_t mk(input logic s, st, h, b, input logic [7:0] pn,
                               input logic [7:0] pc, input logic r, fv, d,
                               input logic [15:0] ic, cc);
      vec_t v;
      v.start = s;  v.stall = st; v.halt = h; v.br = b; v.pcnew = pn;
      v.pc = pc;    v.run = r;    v.fv = fv;  v.done = d;
      v.ic = ic;    v.cc = cc;
      return v;
   endfunction

   task automatic m_reset();
      m_state = 0;
      m_pc    = 0;
      m_ic    = 0;
      m_cc    = 0;
      m_done  = 1'b0;
   endtask

   task automatic m_edge(input vec_t v);
      bit fv;
      fv     = (m_state == 1) && !v.stall;
      m_done = 1'b0;
      if (m_state != 1) begin
         if (v.start) begin
            m_state = 1;
            m_pc    = 0;
            m_ic    = 0;
            m_cc    = 0;
         end
      end else begin
         if (m_cc < CMAX) m_cc++;
         if (fv) begin
            if (m_ic < CMAX) m_ic++;
            if (v.halt) begin
               m_state = 2;
               m_done  = 1'b1;
            end else if (v.br) begin
               m_pc = v.pcnew;
            end else begin
               m_pc = (m_pc + 1) % 256;
            end
         end
      end
   endtask

   function automatic vec_t m_expect(input vec_t v);
      vec_t e;
      e      = v;
      e.pc   = 8'(m_pc);
      e.run  = (m_state == 1);
      e.fv   = (m_state == 1) && !v.stall;
      e.done = m_done;
      e.ic   = 16'(m_ic);
      e.cc   = 16'(m_cc);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered and left at posedge+1; outputs sampled mid-cycle.
   task automatic apply(input string tag, input vec_t v);
      Start        = v.start;
      Stall        = v.stall;
      Halt         = v.halt;
      Branch_Taken = v.br;
      PC_New       = v.pcnew;
      #3;
      chk({tag, ".pc"},   32'(PC_Curr),     32'(v.pc));
      chk({tag, ".run"},  32'(Running),     32'(v.run));
      chk({tag, ".fv"},   32'(Fetch_Valid), 32'(v.fv));
      chk({tag, ".done"}, 32'(Done),        32'(v.done));
      chk({tag, ".ic"},   32'(Instr_Count), 32'(v.ic));
      chk({tag, ".cc"},   32'(Cycle_Count), 32'(v.cc));
      $display("%s: st=%b sl=%b h=%b b=%b pn=%h | pc=%h run=%b fv=%b done=%b ic=%0d cc=%0d",
               tag, v.start, v.stall, v.halt, v.br, v.pcnew,
               PC_Curr, Running, Fetch_Valid, Done, Instr_Count, Cycle_Count);
      @(posedge CLK);
      m_edge(v);
      #1;
   endtask

   task automatic model_step(input string tag, input logic s, st, h, b, input logic [7:0] pn);
      vec_t v;
      v = mk(s, st, h, b, pn, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      apply(tag, m_expect(v));
   endtask

   initial begin
      int nrun;
      int nfetch;

      Reset = 1'b1; rst4 = 1'b1;
      Start = 1'b0; Stall = 1'b0; Halt = 1'b0; Branch_Taken = 1'b0; PC_New = 8'h00;
      start4 = 1'b0; stall4 = 1'b0; halt4 = 1'b0; br4 = 1'b0; pcnew4 = 8'h00;
      m_reset();

      //            s  st h  b  pn     | pc    r  fv d  ic      cc
      tbl[0]  = mk(1, 0, 0, 0, 8'h00,  8'h00, 0, 0, 0, 16'd0,  16'd0);
      tbl[1]  = mk(0, 0, 0, 0, 8'h00,  8'h00, 1, 1, 0, 16'd0,  16'd0);
      tbl[2]  = mk(0, 0, 0, 0, 8'h00,  8'h01, 1, 1, 0, 16'd1,  16'd1);
      tbl[3]  = mk(0, 0, 0, 0, 8'h00,  8'h02, 1, 1, 0, 16'd2,  16'd2);
      tbl[4]  = mk(0, 0, 0, 0, 8'h00,  8'h03, 1, 1, 0, 16'd3,  16'd3);
      tbl[5]  = mk(0, 1, 0, 1, 8'h40,  8'h04, 1, 0, 0, 16'd4,  16'd4);
      tbl[6]  = mk(0, 1, 0, 1, 8'h40,  8'h04, 1, 0, 0, 16'd4,  16'd5);
      tbl[7]  = mk(0, 1, 0, 1, 8'h40,  8'h04, 1, 0, 0, 16'd4,  16'd6);
      tbl[8]  = mk(0, 0, 0, 1, 8'h0F,  8'h04, 1, 1, 0, 16'd4,  16'd7);
      tbl[9]  = mk(0, 0, 0, 1, 8'h10,  8'h0F, 1, 1, 0, 16'd5,  16'd8);
      tbl[10] = mk(0, 0, 0, 1, 8'h00,  8'h10, 1, 1, 0, 16'd6,  16'd9);
      tbl[11] = mk(0, 0, 0, 0, 8'h00,  8'h00, 1, 1, 0, 16'd7,  16'd10);
      tbl[12] = mk(0, 0, 0, 0, 8'h00,  8'h01, 1, 1, 0, 16'd8,  16'd11);
      tbl[13] = mk(0, 0, 1, 1, 8'h33,  8'h02, 1, 1, 0, 16'd9,  16'd12);
      tbl[14] = mk(0, 0, 0, 0, 8'h00,  8'h02, 0, 0, 1, 16'd10, 16'd13);
      tbl[15] = mk(0, 1, 1, 1, 8'h55,  8'h02, 0, 0, 0, 16'd10, 16'd13);
      tbl[16] = mk(1, 0, 0, 0, 8'h00,  8'h02, 0, 0, 0, 16'd10, 16'd13);
      tbl[17] = mk(0, 0, 0, 0, 8'h00,  8'h00, 1, 1, 0, 16'd0,  16'd0);
      tbl[18] = mk(1, 0, 0, 0, 8'h00,  8'h01, 1, 1, 0, 16'd1,  16'd1);
      tbl[19] = mk(0, 0, 0, 0, 8'h00,  8'h02, 1, 1, 0, 16'd2,  16'd2);

      #3;
      chk("rst.pc",   32'(PC_Curr),     32'h00);
      chk("rst.run",  32'(Running),     32'h0);
      chk("rst.fv",   32'(Fetch_Valid), 32'h0);
      chk("rst.done", 32'(Done),        32'h0);
      chk("rst.ic",   32'(Instr_Count), 32'h0);
      chk("rst.cc",   32'(Cycle_Count), 32'h0);
      @(posedge CLK); #1;
      Reset = 1'b0; rst4 = 1'b0;

      for (int i = 0; i < 20; i++) begin
         apply($sformatf("tbl%0d", i), tbl[i]);
      end

      // PC wrap 8'hFF -> 8'h00 on plain increment.
      model_step("wrap_br", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFD);
      model_step("wrap_fd", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("wrap_fe", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("wrap_ff", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #3;
      chk("wrap.pc00", 32'(PC_Curr), 32'h00);
      @(posedge CLK); m_edge(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 16'd0, 16'd0)); #1;

      for (int i = 0; i < 400; i++) begin
         model_step($sformatf("rnd%0d", i),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                    8'($urandom));
      end

      // Reset between edges while a halt is being presented: no Done pulse.
      model_step("mr_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("mr_start2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("mr_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      Halt = 1'b1; Start = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
      #1 Reset = 1'b1;
      #1;
      chk("mr.pc",   32'(PC_Curr),     32'h00);
      chk("mr.run",  32'(Running),     32'h0);
      chk("mr.fv",   32'(Fetch_Valid), 32'h0);
      chk("mr.done", 32'(Done),        32'h0);
      chk("mr.ic",   32'(Instr_Count), 32'h0);
      chk("mr.cc",   32'(Cycle_Count), 32'h0);
      $display("midreset: pc=%h run=%b done=%b ic=%0d cc=%0d",
               PC_Curr, Running, Done, Instr_Count, Cycle_Count);
      @(posedge CLK); #1;
      Start = 1'b1;
      #3;
      chk("mr.done_after_edge", 32'(Done),    32'h0);
      chk("mr.start_vs_reset",  32'(Running), 32'h0);
      @(posedge CLK); #1;
      chk("mr.still_idle", 32'(Running), 32'h0);
      Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
      m_reset();
      model_step("mr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("mr_restart", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      model_step("mr_go", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Narrow counters: both stop at 4'hF.
      start4 = 1'b1;
      @(posedge CLK); #1;
      start4 = 1'b0;
      nrun = 0;
      nfetch = 0;
      for (int k = 0; k < 22; k++) begin
         stall4 = (k % 3 == 0);
         #3;
         chk($sformatf("sat.cc%0d", k), 32'(cc4), 32'((nrun > 15) ? 15 : nrun));
         chk($sformatf("sat.ic%0d", k), 32'(ic4), 32'((nfetch > 15) ? 15 : nfetch));
         $display("sat%0d: stall=%b ic=%h cc=%h", k, stall4, ic4, cc4);
         @(posedge CLK); #1;
         nrun++;
         if (!stall4) nfetch++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
